// File: rtl/dec38_pkg.sv
// Shared types and helpers for the 3:8 decoder and its encoder counterpart.
package dec38_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [0:7] ONEHOT_ZERO = 8'b1000_0000;

  // Code k lights dout[k]; index 0 is the leftmost bit.
  function automatic logic [0:7] onehot3to8(input logic [2:0] code);
    return ONEHOT_ZERO >> code;
  endfunction

endpackage

// File: rtl/dec38_scan_dwell_cnt.sv
// Dwell counter for the scan walk: clr alone zeroes it, clr with inc restarts at 1.
module dec38_dwell_cnt #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [DWELL_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)   r_cnt <= '0;
    else if (clr) r_cnt <= inc ? DWELL_W'(1) : '0;
    else if (inc) r_cnt <= r_cnt + DWELL_W'(1);
  end

  assign hit = (r_cnt == DWELL_W'(DWELL));

endmodule

// File: rtl/dec38_scan.sv
// Registered 3:8 one-hot decoder with a direct-load handshake and a timed 0..7 scan.
module dec38_scan
  import dec38_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       scan_start,
  output logic [0:7] dout,
  output logic [2:0] code_q,
  output logic       out_valid,
  output logic       busy,
  output logic       scan_done
);

  state_e     r_state, w_state_nxt;
  logic [0:7] r_dout, w_dout_nxt;
  logic [2:0] r_code, w_code_nxt;
  logic       r_ov, w_ov_nxt;
  logic       w_cnt_clr, w_cnt_inc, w_hit;

  dec38_dwell_cnt #(.DWELL(DWELL), .DWELL_W(DWELL_W)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .inc   (w_cnt_inc),
    .hit   (w_hit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_dout_nxt  = r_dout;
    w_ov_nxt    = 1'b0;
    w_cnt_clr   = 1'b1;
    w_cnt_inc   = 1'b0;
    if (!en) begin
      // Disable blanks the display and aborts any scan; code_q is kept.
      w_state_nxt = IDLE;
      w_dout_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            w_code_nxt = {a, b, c};
            w_dout_nxt = onehot3to8({a, b, c});
            w_ov_nxt   = 1'b1;
          end else if (scan_start) begin
            w_state_nxt = SCAN;
            w_code_nxt  = 3'd0;
            w_dout_nxt  = ONEHOT_ZERO;
            w_cnt_inc   = 1'b1;
          end
        end
        SCAN: begin
          if (!w_hit) begin
            w_cnt_clr = 1'b0;
            w_cnt_inc = 1'b1;
          end else if (r_code == 3'd7) begin
            w_state_nxt = DONE;
          end else begin
            w_code_nxt = r_code + 3'd1;
            w_dout_nxt = onehot3to8(r_code + 3'd1);
            w_cnt_inc  = 1'b1;
          end
        end
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dout  <= '0;
      r_code  <= 3'd0;
      r_ov    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dout  <= w_dout_nxt;
      r_code  <= w_code_nxt;
      r_ov    <= w_ov_nxt;
    end
  end

  assign in_ready  = rst_n & en & (r_state == IDLE);
  assign dout      = r_dout;
  assign code_q    = r_code;
  assign out_valid = r_ov;
  assign busy      = (r_state != IDLE);
  assign scan_done = (r_state == DONE);

endmodule

// File: tb/tb_dec38_scan.sv
// Bench for dec38_scan: vector table of direct loads, scan walks at DWELL=4 and DWELL=1, corner sequences.
module tb_dec38_scan;
  localparam int DW = 4;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0;
  logic in_valid = 1'b0, scan_start = 1'b0;
  logic in_ready, out_valid, busy, scan_done;
  logic [0:7] dout;
  logic [2:0] code_q;
  logic in_ready1, out_valid1, busy1, scan_done1;
  logic [0:7] dout1;
  logic [2:0] code_q1;

  int vectors = 0, miscompares = 0;

  typedef struct {logic [2:0] code; logic [0:7] dout;} vec_t;
  typedef struct {logic [2:0] code; logic [0:7] dout; logic ov; logic bsy;} exp_t;
  exp_t sb[$];
  vec_t tbl[8];

  dec38_scan #(.DWELL(DW), .DWELL_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c), .in_valid(in_valid),
    .in_ready(in_ready), .scan_start(scan_start), .dout(dout), .code_q(code_q),
    .out_valid(out_valid), .busy(busy), .scan_done(scan_done));

  dec38_scan #(.DWELL(1), .DWELL_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c), .in_valid(in_valid),
    .in_ready(in_ready1), .scan_start(scan_start), .dout(dout1), .code_q(code_q1),
    .out_valid(out_valid1), .busy(busy1), .scan_done(scan_done1));

  always #5 clk = ~clk;

  // Independent behavioural 8:3 encoder for the loopback check.
  function automatic logic [2:0] enc83beh(input logic [0:7] d);
    enc83beh = 3'd0;
    for (int k = 0; k < 8; k++) if (d[k]) enc83beh = 3'(k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [2:0] cd, input logic [0:7] d, input logic ov, input logic bsy);
    exp_t e;
    e.code = cd; e.dout = d; e.ov = ov; e.bsy = bsy;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({nm, " dout"}, 32'(dout), 32'(e.dout));
    chk({nm, " code_q"}, 32'(code_q), 32'(e.code));
    chk({nm, " out_valid"}, 32'(out_valid), 32'(e.ov));
    chk({nm, " busy"}, 32'(busy), 32'(e.bsy));
    chk({nm, " loopback"}, 32'(enc83beh(dout)), 32'(e.code));
  endtask

  // Output must never show more than one hot bit.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot dwell4", 32'($countones(dout) <= 1), 32'd1);
      chk("onehot dwell1", 32'($countones(dout1) <= 1), 32'd1);
    end
  end

  initial begin
    logic [2:0] k;
    logic [0:7] base;
    base = 8'b1000_0000;
    tbl[0] = '{3'd5, 8'b0000_0100};
    tbl[1] = '{3'd0, 8'b1000_0000};
    tbl[2] = '{3'd7, 8'b0000_0001};
    tbl[3] = '{3'd3, 8'b0001_0000};
    tbl[4] = '{3'd1, 8'b0100_0000};
    tbl[5] = '{3'd2, 8'b0010_0000};
    tbl[6] = '{3'd4, 8'b0000_1000};
    tbl[7] = '{3'd6, 8'b0000_0010};

    // Reset
    @(negedge clk);
    tick(); tick();
    chk("reset dout", 32'(dout), 32'd0);
    chk("reset code_q", 32'(code_q), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset scan_done", 32'(scan_done), 32'd0);
    rst_n = 1'b1; en = 1'b1;
    #1 chk("idle in_ready", 32'(in_ready), 32'd1);

    // Back-to-back direct loads from the table
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = tbl[i].code;
      in_valid = 1'b1;
      push_exp(tbl[i].code, tbl[i].dout, 1'b1, 1'b0);
      tick();
      check_sb("load");
    end
    in_valid = 1'b0;
    push_exp(3'd6, 8'b0000_0010, 1'b0, 1'b0);
    tick();
    check_sb("hold");

    // Scan: both DUTs start together; DWELL=4 via scoreboard, DWELL=1 directly
    scan_start = 1'b1;
    for (int n = 1; n <= 8 * DW; n++) begin
      k = 3'((n - 1) / DW);
      push_exp(k, base >> k, 1'b0, 1'b1);
      tick();
      scan_start = 1'b0;
      check_sb("scan");
      chk("scan in_ready", 32'(in_ready), 32'd0);
      chk("scan done early", 32'(scan_done), 32'd0);
      if (n <= 8) begin
        chk("dw1 code", 32'(code_q1), 32'(n - 1));
        chk("dw1 dout", 32'(dout1), 32'(base >> (n - 1)));
      end
      chk("dw1 scan_done", 32'(scan_done1), 32'(n == 9));
      chk("dw1 busy", 32'(busy1), 32'(n <= 9));
      // Load and restart requests while busy must be ignored
      if (n == 4) begin in_valid = 1'b1; {a, b, c} = 3'd3; scan_start = 1'b1; end
      if (n == 6) begin in_valid = 1'b0; scan_start = 1'b0; end
    end
    tick();
    chk("done pulse", 32'(scan_done), 32'd1);
    chk("done busy", 32'(busy), 32'd1);
    chk("done dout", 32'(dout), 32'h01);
    chk("done code_q", 32'(code_q), 32'd7);
    tick();
    chk("after done pulse", 32'(scan_done), 32'd0);
    chk("after done busy", 32'(busy), 32'd0);
    chk("after done in_ready", 32'(in_ready), 32'd1);
    chk("after done dout", 32'(dout), 32'h01);

    // Load beats a simultaneous scan request
    {a, b, c} = 3'b010; in_valid = 1'b1; scan_start = 1'b1;
    push_exp(3'd2, 8'b0010_0000, 1'b1, 1'b0);
    tick();
    check_sb("simul");
    in_valid = 1'b0; scan_start = 1'b0;
    tick();
    chk("simul no scan busy", 32'(busy), 32'd0);
    chk("simul dout", 32'(dout), 32'h20);

    // Abort by en in the third cycle of code 4, then restart
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (4 * DW + 2) tick();
    chk("abort code4", 32'(code_q), 32'd4);
    en = 1'b0;
    tick();
    chk("abort dout", 32'(dout), 32'd0);
    chk("abort code_q", 32'(code_q), 32'd4);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd0);
    repeat (3) begin
      tick();
      chk("abort no done", 32'(scan_done), 32'd0);
    end
    en = 1'b1; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    chk("restart code_q", 32'(code_q), 32'd0);
    chk("restart dout", 32'(dout), 32'h80);
    chk("restart busy", 32'(busy), 32'd1);
    for (int w = 0; w < 100 && !scan_done; w++) tick();
    chk("restart done", 32'(scan_done), 32'd1);
    chk("restart last code", 32'(code_q), 32'd7);
    tick();

    // Reset mid-scan
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst dout", 32'(dout), 32'd0);
    chk("midrst code_q", 32'(code_q), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("midrst no done", 32'(scan_done), 32'd0);
      chk("midrst idle", 32'(busy), 32'd0);
    end

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dec38_scan.md
Name: dec38_scan

Overview:
- Registered 3:8 binary-to-one-hot decoder: the inverse of the team's 8:3 encoder.
- Mapping: code {a,b,c} = k drives dout[k] high, with dout indexed [0:7]. Code 0 gives dout = 8'b10000000; code 7 gives 8'b00000001.
- Two operating modes:
  - Direct mode: loads one code through a valid/ready handshake.
  - Scan mode: walks all eight outputs in order, each held for a programmable dwell. Used for row/LED scanning and for closed-loop self-test of the encoder.

Parameters:
DWELL, 4, clock cycles each code is held during scan; legal range 1..255
DWELL_W, 8, width of the internal dwell counter; must satisfy DWELL <= 2**DWELL_W - 1

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_n  in  1  reset, synchronous, active-low
en  in  1  global enable; when low, dout is cleared and no operation is accepted
a  in  1  code MSB
b  in  1  code middle bit
c  in  1  code LSB
in_valid  in  1  {a,b,c} is valid this cycle
in_ready  out  1  block accepts a direct load this cycle
scan_start  in  1  request a full 0..7 scan
dout  out  [0:7]  registered one-hot output; dout[k] = 1 for code k
code_q  out  3  registered binary code currently shown on dout
out_valid  out  1  one-cycle pulse when dout has been updated by a direct load
busy  out  1  high in SCAN and DONE states
scan_done  out  1  one-cycle pulse after the last scan code completes

Behaviour:
- Reset, synchronous, while rst_n = 0 at a clock edge:
  - dout = 8'b00000000, code_q = 3'd0, out_valid = 0, scan_done = 0, state = IDLE, dwell counter = 0.
  - in_ready is forced 0 while rst_n is low.
- Reset mid-scan aborts the scan immediately. No scan_done pulse is issued.
- in_ready = rst_n & en & (state == IDLE). It is combinational from the registered state.
- Direct load:
  - A transfer occurs when in_valid & in_ready are both high at edge T.
  - At T+1: code_q = {a,b,c} sampled at T, dout = one-hot of that code, out_valid = 1 for exactly one cycle.
  - Latency is 1 cycle. Back-to-back loads on consecutive cycles are legal, and out_valid stays high for each of them.
- dout holds its last value until the next load, scan step, en = 0, or reset.
- States: IDLE, SCAN, DONE.
- IDLE -> SCAN:
  - Condition: scan_start & en & !in_valid.
  - At T+1: code_q = 0, dout = 8'b10000000, dwell counter = 1.
- In IDLE, in_valid and scan_start high in the same cycle: the load wins, scan_start is ignored and must be reissued.
- SCAN:
  - Each code is held for exactly DWELL cycles.
  - When the dwell counter equals DWELL and code_q < 7: code_q increments, dout shifts the one-hot right by one position, and the dwell counter reloads to 1.
  - When the dwell counter equals DWELL and code_q == 7: go to DONE.
  - dout keeps 8'b00000001.
- DONE:
  - Lasts one cycle with scan_done = 1, then returns to IDLE.
  - dout retains 8'b00000001 after the scan.
- Total scan: the scan starts at edge T. dout shows codes 0..7 over cycles T+1 .. T+8*DWELL. scan_done is high in cycle T+8*DWELL+1.
- DWELL = 1: the code changes every cycle. No skipped and no repeated codes.
- scan_start while busy is ignored. in_valid while busy is not accepted because in_ready = 0.
- en = 0 at any edge:
  - Next cycle: dout = 0, code_q unchanged, state = IDLE, dwell counter = 0, out_valid = 0.
  - An active scan is aborted without scan_done.
- dout is always zero-hot or one-hot; never more than one bit is set.
- The dwell counter never wraps. Because DWELL <= 2**DWELL_W - 1, it always reaches DWELL before overflow.

Decomposition:
- Shared package dec38_pkg contains:
  - state enum {IDLE, SCAN, DONE};
  - constant ONEHOT_ZERO = 8'b10000000;
  - function onehot3to8(code) returning [0:7].
- The encoder testbench reuses the same package for its loopback check.
- One sub-module, dec38_dwell_cnt: a DWELL_W-bit counter with inputs clr, inc and output hit (count == DWELL). It is instantiated once.

Test Plan:
- Reset then load: rst_n low 2 cycles, then en = 1; in_valid with {a,b,c} = 3'b101 -> next cycle dout = 8'b00000100, code_q = 5, out_valid = 1 for one cycle.
- Back-to-back loads: codes 0, 7, 3 on consecutive cycles -> dout = 10000000, 00000001, 00010000 on the following three cycles; out_valid stays high for 3 cycles.
- Scan with DWELL = 4: scan_start at cycle 10 -> dout walks 10000000..00000001, each code held 4 cycles, over cycles 11..42; scan_done = 1 in cycle 43; busy high in cycles 11..43; in_ready low throughout.
- Simultaneous request: in_valid ({a,b,c} = 3'b010) and scan_start in the same IDLE cycle -> dout = 8'b00100000, busy stays 0, no scan occurs.
- Abort: en dropped in the 3rd cycle of code 4 during a scan -> next cycle dout = 0, state = IDLE, no scan_done; re-enabling with scan_start restarts from code 0.
- Loopback: feed dout into enc83beh for every direct code 0..7 and for every scan step -> the encoder's {a,b,c} equals code_q on every cycle.
